uart_tx_msg_builder: RTL

Response-frame serializer for the UART TX path: accepts one response request from the register/pixel back end, then emits the complete brace-delimited ASCII frame one byte at a time to the UART transmitter. It is the transmit-side counterpart of the RX message parser and uses the same frame grammar: `{`, opcode, three-byte fields separated by `,`, and `}`. Throughput is at most one byte per cycle. Downstream back-pressure is honoured per byte.

---
 rtl/uart_tx_msg_builder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_msg_builder.sv
// uart_tx_msg_builder: serializes one response request into a brace-delimited
// ASCII frame for the UART TX path. Optional macro: MSG_TX_ASCII_EN.
module uart_tx_msg_builder #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [1:0]  rsp_kind,
  input  logic [11:0] rsp_addr,
  input  logic [15:0] rsp_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  localparam logic [7:0] C_LBR = 8'h7B;
  localparam logic [7:0] C_RBR = 8'h7D;
  localparam logic [7:0] C_COM = 8'h2C;
  localparam logic [7:0] C_R   = 8'h52;
  localparam logic [7:0] C_W   = 8'h57;
  localparam logic [7:0] C_E   = 8'h45;
  localparam logic [7:0] C_V   = 8'h56;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [1:0]  kind_q, kind_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        done_q, done_d;

  logic [3:0]  last_idx;
  logic [3:0]  next_idx;
  logic        byte_hs;

  // Nibble encoding differs between ASCII-hex and raw builds.
  function automatic logic [7:0] nib(input logic [3:0] n);
`ifdef MSG_TX_ASCII_EN
    if (n < 4'd10) nib = 8'h30 + {4'h0, n};
    else           nib = 8'h37 + {4'h0, n};
`else
    nib = {4'h0, n};
`endif
  endfunction

  // Byte idx of the frame for a captured request.
  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic [1:0]  kind,
    input logic [11:0] addr,
    input logic [15:0] data
  );
    logic [11:0] a;
    logic [7:0]  op;
    a  = (kind == 2'd3) ? 12'hFFF : addr;
    op = (kind == 2'd1) ? C_W : C_E;
    frame_byte = C_RBR;
    if (kind == 2'd0) begin
      case (idx)
        4'd0:    frame_byte = C_LBR;
        4'd1:    frame_byte = C_R;
        4'd2:    frame_byte = nib(a[11:8]);
        4'd3:    frame_byte = nib(a[7:4]);
        4'd4:    frame_byte = nib(a[3:0]);
        4'd5:    frame_byte = C_COM;
        4'd6:    frame_byte = C_V;
        4'd7:    frame_byte = nib(4'h0);
        4'd8:    frame_byte = nib(data[15:12]);
        4'd9:    frame_byte = nib(data[11:8]);
        4'd10:   frame_byte = C_COM;
        4'd11:   frame_byte = C_V;
        4'd12:   frame_byte = nib(4'h0);
        4'd13:   frame_byte = nib(data[7:4]);
        4'd14:   frame_byte = nib(data[3:0]);
        default: frame_byte = C_RBR;
      endcase
    end else begin
      case (idx)
        4'd0:    frame_byte = C_LBR;
        4'd1:    frame_byte = op;
        4'd2:    frame_byte = nib(a[11:8]);
        4'd3:    frame_byte = nib(a[7:4]);
        4'd4:    frame_byte = nib(a[3:0]);
        default: frame_byte = C_RBR;
      endcase
    end
  endfunction

  assign last_idx = (kind_q == 2'd0) ? 4'd15 : 4'd5;
  assign next_idx = idx_q + 4'd1;
  assign byte_hs  = tx_valid_q && tx_ready;

  // Next-state logic: accept, walk the frame bytes, then optional gap.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rsp_valid) begin
          kind_d     = rsp_kind;
          addr_d     = rsp_addr;
          data_d     = rsp_data;
          idx_d      = 4'd0;
          tx_data_d  = C_LBR;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (byte_hs) begin
          if (idx_q == last_idx) begin
            idx_d      = 4'd0;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d     = next_idx;
            tx_data_d = frame_byte(next_idx, kind_q, addr_q, data_q);
          end
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        idx_d      = 4'd0;
        gap_d      = 8'd0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      gap_q      <= 8'd0;
      kind_q     <= 2'd0;
      addr_q     <= 12'd0;
      data_q     <= 16'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign rsp_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_done = done_q;

endmodule
